// File: rtl/mem_sram_bridge_pkg.sv
// rtl/mem_sram_bridge_pkg.sv - shared encodings and helpers for the CPU-to-byte-SRAM bridge
package mem_sram_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Size 11 is reported through the same error path as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - little-endian byte select for writes and byte merge for reads
module mem_byte_lane (
  input  logic [31:0] wdata,
  input  logic [1:0]  wr_idx,
  output logic [7:0]  wr_byte,
  input  logic [31:0] rbuf,
  input  logic [7:0]  rd_byte,
  input  logic [1:0]  rd_idx,
  output logic [31:0] rbuf_merged
);

  always_comb begin
    wr_byte     = wdata[{wr_idx, 3'b000} +: 8];
    rbuf_merged = rbuf;
    rbuf_merged[{rd_idx, 3'b000} +: 8] = rd_byte;
  end

endmodule

// File: rtl/mem_sram_bridge.sv
// rtl/mem_sram_bridge.sv - services CPU byte/half/word accesses as byte sub-accesses
// on an asynchronous byte-wide SRAM with WAIT extra cycles per byte.
module mem_sram_bridge
  import mem_sram_bridge_pkg::*;
#(
  parameter int AW   = 16,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mReq,
  input  logic [31:0]   mAddr,
  input  logic [31:0]   mDo,
  input  logic [1:0]    mSize,
  input  logic          mWr,
  output logic [31:0]   mDi,
  output logic          mRdy,
  output logic          mErr,
  output logic [AW-1:0] sAddr,
  output logic [7:0]    sDo,
  input  logic [7:0]    sDi,
  output logic          sCe,
  output logic          sOe,
  output logic          sWe
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    wc_q, wc_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [31:0]   mdi_q, mdi_d;
  logic          mrdy_q, mrdy_d;
  logic          merr_q, merr_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic [7:0]    sdo_q, sdo_d;
  logic          sce_q, sce_d;
  logic          soe_q, soe_d;
  logic          swe_q, swe_d;

  logic [1:0]    idx_nxt;
  logic [7:0]    lane_wr_byte;
  logic [31:0]   lane_rbuf;
  logic          unused_addr_hi;

  // Upper address bits alias onto the SRAM space.
  assign unused_addr_hi = ^mAddr[31:AW];
  assign idx_nxt        = idx_q + 2'd1;

  // The write side looks one byte ahead so sDo is registered alongside sAddr.
  mem_byte_lane u_lane (
    .wdata       (wdata_q),
    .wr_idx      (idx_nxt),
    .wr_byte     (lane_wr_byte),
    .rbuf        (rbuf_q),
    .rd_byte     (sDi),
    .rd_idx      (idx_q),
    .rbuf_merged (lane_rbuf)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    wc_d     = wc_q;
    rbuf_d   = rbuf_q;
    mdi_d    = mdi_q;
    mrdy_d   = mrdy_q;
    merr_d   = merr_q;
    saddr_d  = saddr_q;
    sdo_d    = sdo_q;
    sce_d    = sce_q;
    soe_d    = soe_q;
    swe_d    = swe_q;

    case (state_q)
      IDLE: begin
        if (mReq) begin
          base_d  = mAddr[AW-1:0];
          wdata_d = mDo;
          wr_d    = mWr;
          if (misaligned(mSize, mAddr[1:0])) begin
            state_d = DONE;
            mrdy_d  = 1'b1;
            merr_d  = 1'b1;
          end else begin
            state_d  = ACC;
            nbytes_d = nbytes(mSize);
            idx_d    = 2'd0;
            wc_d     = 4'd0;
            rbuf_d   = 32'h0;
            saddr_d  = mAddr[AW-1:0];
            sdo_d    = mDo[7:0];
            sce_d    = 1'b1;
            soe_d    = ~mWr;
            swe_d    = mWr;
          end
        end
      end

      ACC: begin
        if (wc_q == WAIT_C) begin
          wc_d = 4'd0;
          if (!wr_q) begin
            rbuf_d = lane_rbuf;
          end
          if (({1'b0, idx_q} + 3'd1) == nbytes_q) begin
            state_d = DONE;
            mrdy_d  = 1'b1;
            sce_d   = 1'b0;
            soe_d   = 1'b0;
            swe_d   = 1'b0;
            if (!wr_q) begin
              mdi_d = lane_rbuf;
            end
          end else begin
            idx_d   = idx_nxt;
            saddr_d = base_q + AW'(idx_nxt);
            sdo_d   = lane_wr_byte;
          end
        end else begin
          wc_d = wc_q + 4'd1;
        end
      end

      DONE: begin
        mrdy_d  = 1'b0;
        merr_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      wdata_q  <= 32'h0;
      wr_q     <= 1'b0;
      nbytes_q <= 3'd0;
      idx_q    <= 2'd0;
      wc_q     <= 4'd0;
      rbuf_q   <= 32'h0;
      mdi_q    <= 32'h0;
      mrdy_q   <= 1'b0;
      merr_q   <= 1'b0;
      saddr_q  <= '0;
      sdo_q    <= 8'h0;
      sce_q    <= 1'b0;
      soe_q    <= 1'b0;
      swe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      nbytes_q <= nbytes_d;
      idx_q    <= idx_d;
      wc_q     <= wc_d;
      rbuf_q   <= rbuf_d;
      mdi_q    <= mdi_d;
      mrdy_q   <= mrdy_d;
      merr_q   <= merr_d;
      saddr_q  <= saddr_d;
      sdo_q    <= sdo_d;
      sce_q    <= sce_d;
      soe_q    <= soe_d;
      swe_q    <= swe_d;
    end
  end

  assign mDi   = mdi_q;
  assign mRdy  = mrdy_q;
  assign mErr  = merr_q;
  assign sAddr = saddr_q;
  assign sDo   = sdo_q;
  assign sCe   = sce_q;
  assign sOe   = soe_q;
  assign sWe   = swe_q;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// tb/tb_mem_sram_bridge.sv - directed self-checking bench for mem_sram_bridge
module tb_mem_sram_bridge;

  logic        clk;
  logic        rst;
  logic        mReq;
  logic [31:0] mAddr;
  logic [31:0] mDo;
  logic [1:0]  mSize;
  logic        mWr;
  logic [31:0] mDi;
  logic        mRdy;
  logic        mErr;
  logic [15:0] sAddr;
  logic [7:0]  sDo;
  logic [7:0]  sDi;
  logic        sCe;
  logic        sOe;
  logic        sWe;

  logic [7:0]  mem [0:65535];
  logic [15:0] alog [0:31];

  int pass_cnt;
  int total_cnt;

  mem_sram_bridge #(.AW(16), .WAIT(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .mReq  (mReq),
    .mAddr (mAddr),
    .mDo   (mDo),
    .mSize (mSize),
    .mWr   (mWr),
    .mDi   (mDi),
    .mRdy  (mRdy),
    .mErr  (mErr),
    .sAddr (sAddr),
    .sDo   (sDo),
    .sDi   (sDi),
    .sCe   (sCe),
    .sOe   (sOe),
    .sWe   (sWe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: combinational read, write while CE and WE are high.
  assign sDi = (sCe && sOe) ? mem[sAddr] : 8'h00;
  always @(posedge clk) begin
    if (sCe && sWe) mem[sAddr] <= sDo;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one request, scrambles the request pins after acceptance, and
  // records per-cycle sCe/sWe/sAddr until mRdy (cycle budget 30).
  task automatic run(input logic [31:0] a, input logic [1:0] sz, input logic w,
                     input logic [31:0] d, output int lat, output logic [31:0] sce_m,
                     output logic [31:0] swe_m, output logic err, output logic after);
    @(negedge clk);
    mReq = 1'b1; mAddr = a; mSize = sz; mWr = w; mDo = d;
    @(posedge clk);
    lat = -1; sce_m = 32'h0; swe_m = 32'h0; err = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      mAddr = 32'hFFFF_FFFF; mDo = 32'h0; mSize = 2'b11; mWr = ~w;
      sce_m[k] = sCe;
      swe_m[k] = sWe;
      alog[k]  = sAddr;
      if (mRdy) begin
        lat  = k;
        err  = mErr;
        mReq = 1'b0;
        break;
      end
    end
    mReq = 1'b0;
    @(negedge clk);
    after = mRdy | mErr;
  endtask

  int          lat;
  logic [31:0] sce_m, swe_m;
  logic        err, after;
  logic        rdy_seen;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h78; mem[16'h0011] = 8'h56; mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h12;
    mem[16'h0024] = 8'h77;
    mem[16'hFFFC] = 8'h11; mem[16'hFFFD] = 8'h22; mem[16'hFFFE] = 8'h33; mem[16'hFFFF] = 8'h44;
    mem[16'h0040] = 8'h55; mem[16'h0041] = 8'h55; mem[16'h0042] = 8'h55;

    rst = 1'b1; mReq = 1'b0; mAddr = 32'h0; mDo = 32'h0; mSize = 2'b00; mWr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mdi", mDi, 32'h0);
    chk("rst_ctl", {28'h0, mRdy, mErr, sCe, sOe}, 32'h0);
    chk("rst_swe_addr_do", {7'h0, sWe, sAddr, sDo}, 32'h0);
    rst = 1'b0;

    // Word read, WAIT=1: two cycles per byte, mRdy in cycle 9.
    run(32'h0000_0010, 2'b10, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("wrd_lat", lat, 32'd9);
    chk("wrd_mdi", mDi, 32'h1234_5678);
    chk("wrd_err", {31'h0, err}, 32'h0);
    chk("wrd_sce", sce_m, 32'h0000_01FE);
    chk("wrd_a1", {16'h0, alog[1]}, 32'h10);
    chk("wrd_a2", {16'h0, alog[2]}, 32'h10);
    chk("wrd_a3", {16'h0, alog[3]}, 32'h11);
    chk("wrd_a8", {16'h0, alog[8]}, 32'h13);
    chk("wrd_after", {31'h0, after}, 32'h0);

    // Half write: bytes EF, BE; neighbour byte untouched; mDi keeps last read.
    run(32'h0000_0022, 2'b01, 1'b1, 32'hDEAD_BEEF, lat, sce_m, swe_m, err, after);
    chk("hw_lat", lat, 32'd5);
    chk("hw_swe", swe_m, 32'h0000_001E);
    chk("hw_mem", {8'h0, mem[16'h0024], mem[16'h0023], mem[16'h0022]}, 32'h0077_BEEF);
    chk("hw_mdi", mDi, 32'h1234_5678);

    // Byte read through the aliased upper address.
    mem[16'h0013] = 8'h9A;
    run(32'h0001_0013, 2'b00, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("br_lat", lat, 32'd3);
    chk("br_mdi", mDi, 32'h0000_009A);
    chk("br_addr", {16'h0, alog[1]}, 32'h13);

    // Misaligned word and illegal size: error in cycle 1, no SRAM cycle.
    run(32'h0000_0006, 2'b10, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("mis_lat", lat, 32'd1);
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_sce", sce_m, 32'h0);
    chk("mis_mdi", mDi, 32'h0000_009A);
    chk("mis_after", {31'h0, after}, 32'h0);
    run(32'h0000_0000, 2'b11, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("ill_lat", lat, 32'd1);
    chk("ill_err", {31'h0, err}, 32'h1);
    chk("ill_sce", sce_m, 32'h0);
    chk("ill_mdi", mDi, 32'h0000_009A);

    // Top of the SRAM space.
    run(32'h0000_FFFC, 2'b10, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("top_lat", lat, 32'd9);
    chk("top_mdi", mDi, 32'h4433_2211);
    chk("top_a1", {16'h0, alog[1]}, 32'hFFFC);
    chk("top_a8", {16'h0, alog[8]}, 32'hFFFF);
    run(32'h0000_FFFF, 2'b01, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("top_hlat", lat, 32'd1);
    chk("top_herr", {31'h0, err}, 32'h1);
    chk("top_hmdi", mDi, 32'h4433_2211);

    // Reset in cycle 4 of a word write.
    @(negedge clk);
    mReq = 1'b1; mAddr = 32'h0000_0040; mSize = 2'b10; mWr = 1'b1; mDo = 32'hCAFE_F00D;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {29'h0, sCe, sWe, mRdy}, 32'h0);
    mReq = 1'b0;
    rdy_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rdy_seen = rdy_seen | mRdy;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      rdy_seen = rdy_seen | mRdy;
    end
    chk("rst_mid_rdy", {31'h0, rdy_seen}, 32'h0);
    chk("rst_mid_mem", {8'h0, mem[16'h0042], mem[16'h0041], mem[16'h0040]}, 32'h0055_F00D);
    chk("rst_mid_mdi", mDi, 32'h0);

    run(32'h0000_0013, 2'b00, 1'b0, 32'h0, lat, sce_m, swe_m, err, after);
    chk("post_lat", lat, 32'd3);
    chk("post_mdi", mDi, 32'h0000_009A);
    chk("post_err", {31'h0, err}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
